// File: rtl/mem_arbiter_if.sv
// Bundles the instruction port, data port and RAM-side signals of the memory arbiter.
// The arbiter uses the slave modport; the requester/RAM environment uses master.
interface mem_arbiter_if;
  // instruction requester
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  // data requester
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  // RAM
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data side has priority over instruction side, one RAM
// transaction outstanding, ERROR responses retried up to RETRY_MAX times before the
// transaction completes with zero data.
module mem_arbiter #(
  parameter int unsigned RETRY_MAX = 15
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT, RETRY} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wen_q, wen_d;
  logic        dside_q, dside_d;  // grant state to resume after RETRY
  logic [3:0]  retry_q, retry_d;

  logic        abort;
  logic        cpl;
  logic [31:0] cpl_data;

  logic        iwait, dwait, ram_ren, ram_wen;
  logic [31:0] iload, dload, ram_addr, ram_store;

  // State and latched-request registers; reset drops any RAM request at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      dside_q <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
      dside_q <= dside_d;
      retry_q <= retry_d;
    end
  end

  // Arbitration, RAM handshake, retry/abort handling and requester responses.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wen_d     = wen_q;
    dside_d   = dside_q;
    retry_d   = retry_q;
    abort     = 1'b0;
    cpl       = 1'b0;
    cpl_data  = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_d = DGRANT;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wen_d   = bus.dWEN;  // read+write together counts as a write
          dside_d = 1'b1;
        end else if (bus.iREN) begin
          state_d = IGRANT;
          addr_d  = bus.iaddr;
          store_d = '0;
          wen_d   = 1'b0;
          dside_d = 1'b0;
        end
      end
      IGRANT, DGRANT: begin
        ram_ren   = ~wen_q;
        ram_wen   = wen_q;
        ram_addr  = addr_q;
        ram_store = store_q;
        if (state_q == IGRANT) begin
          abort = !bus.iREN || (bus.iaddr != addr_q);
        end else begin
          abort = !(bus.dREN || bus.dWEN) || (bus.daddr != addr_q);
        end
        // A requester that walked away gets nothing, even if the RAM finished.
        if (abort) begin
          state_d = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          cpl      = 1'b1;
          cpl_data = wen_q ? 32'd0 : bus.ramload;
          state_d  = IDLE;
        end else if (bus.ramstate == RAM_ERROR) begin
          if (retry_q == RETRY_MAX[3:0]) begin
            cpl     = 1'b1;
            state_d = IDLE;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = RETRY;
          end
        end
      end
      RETRY: begin
        state_d = dside_q ? DGRANT : IGRANT;
      end
      default: state_d = IDLE;
    endcase

    if (cpl) begin
      if (dside_q) begin
        dwait = 1'b0;
        dload = cpl_data;
      end else begin
        iwait = 1'b0;
        iload = cpl_data;
      end
    end

    if (state_d == IDLE) begin
      retry_d = '0;
    end
  end

  assign bus.iwait    = iwait;
  assign bus.iload    = iload;
  assign bus.dwait    = dwait;
  assign bus.dload    = dload;
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 15: ERROR responses tolerated per transaction before completing with zero data.
REQ-002 SHALL have ports: CLK  in  1  clock, rising edge; nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: iREN  in  1  instruction read request; iaddr  in  32  instruction address; iwait  out  1  low for exactly the completion cycle; iload  out  32  instruction data.
REQ-004 SHALL have ports: dREN  in  1  data read request; dWEN  in  1  data write request; daddr  in  32  data address; dstore  in  32  write data; dwait  out  1  low for exactly the completion cycle; dload  out  32  read data.
REQ-005 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; ramload  in  32; ramstate  in  2  (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).

Function
REQ-006 SHALL implement FSM states IDLE, IGRANT, DGRANT, RETRY, with one outstanding RAM transaction at a time.
REQ-007 In IDLE, a request with dREN|dWEN SHALL win over iREN: go to DGRANT, latch daddr, dstore, dWEN; else iREN -> IGRANT, latch iaddr; else stay.
REQ-008 dREN and dWEN both high SHALL be treated as a write.
REQ-009 In IGRANT/DGRANT, ramaddr/ramstore/ramREN/ramWEN SHALL be driven only from latched values; in IDLE and RETRY all four are 0.
REQ-010 ramstate==ACCESS in a grant state SHALL complete it: same cycle, the owner's wait goes low and its load equals ramload (dload 0 for writes); next state IDLE.
REQ-011 Minimum latency SHALL be 2 cycles: request sampled in cycle 0, completion in cycle 1 if ramstate==ACCESS.
REQ-012 ramstate FREE/BUSY in a grant state SHALL hold the state, both waits high.
REQ-013 ramstate==ERROR SHALL go to RETRY for one cycle (RAM deasserted), then return to the same grant state with the same latched values, and increment a 4-bit retry counter.
REQ-014 When the retry counter reaches RETRY_MAX, the next ERROR SHALL complete the transaction with load 0 and wait low for one cycle.
REQ-015 In IGRANT, if iREN drops or iaddr differs from the latched address, the transaction SHALL abort: no wait-low pulse, next state IDLE.
REQ-016 The DGRANT abort rule SHALL be the same, applied when dREN and dWEN both drop or daddr changes.
REQ-017 An abort and ACCESS in the same cycle SHALL produce an abort; the data is discarded.
REQ-018 A requester still asserting after completion SHALL be rearbitrated in IDLE the next cycle; no back-to-back grant without passing through IDLE.
REQ-019 A non-owner's wait SHALL stay high and its load SHALL be 0 throughout.
REQ-020 The retry counter SHALL clear on every entry to IDLE.

Reset
REQ-021 nRST low SHALL immediately force IDLE; iwait=dwait=1; iload=dload=0; ramREN=ramWEN=0; ramaddr=ramstore=0; retry counter 0.
REQ-022 Reset mid-transaction SHALL drop the RAM request with no completion pulse; the first request after release is arbitrated as from IDLE.

Verification
- iREN=1, iaddr=0x40, ramstate ACCESS on the first grant cycle, ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 in cycle 1; iwait=0, iload=0x8C010004 in cycle 1; IDLE in cycle 2.
- iREN and dWEN both high, daddr=0x100, dstore=0xDEADBEEF -> DGRANT with ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; iwait stays 1; IGRANT follows completion.
- DGRANT read with ramstate BUSY 3 cycles then ACCESS -> dwait high 3 cycles, then low 1 cycle with dload=ramload.
- ERROR twice, then ACCESS -> two RETRY cycles with ramREN=0; same ramaddr reissued; completion carries ramload; retry counter back to 0 in IDLE.
- ERROR 16 times with RETRY_MAX=15 -> wait low, load=0 on the 16th ERROR.
- IGRANT with iREN dropped before ACCESS; separately, nRST pulsed mid-DGRANT -> no iwait/dwait low pulse; IDLE next cycle or immediately; all RAM outputs 0.
